// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter and its result FIFOs.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_MD,
    SRC_ACC
  } src_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Small result FIFO for one multi-cycle producer; head entry is readable combinationally.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      assert (!(i_push && o_full)) else $error("wb_fifo overflow");
      assert (!(i_pop && o_empty)) else $error("wb_fifo underflow");
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline results have priority, MUL/DIV and accelerator results
// are buffered and round-robined into the free slots, with a starvation stall.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic [ADDR_W-1:0] acc_rd,
  input  logic [DATA_W-1:0] acc_data,
  output logic              stall_req,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  localparam int ENT_W  = ADDR_W + DATA_W;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SCNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [SCNT_W-1:0] STARVE_LIM = SCNT_W'(STARVE_MAX);

  logic              w_md_full, w_md_empty, w_md_push, w_md_enq, w_md_pop;
  logic              w_acc_full, w_acc_empty, w_acc_push, w_acc_enq, w_acc_pop;
  logic [ENT_W-1:0]  w_md_dout, w_acc_dout;
  logic [FCNT_W-1:0] w_md_count, w_acc_count;
  logic              w_pipe_req;
  src_e              w_grant;
  logic [SCNT_W-1:0] w_md_starve_next, w_acc_starve_next;

  src_e              r_rr_ptr;
  logic [SCNT_W-1:0] r_md_starve, r_acc_starve;
  logic              r_stall_req;
  logic              r_wb_en;
  logic [ADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;

  assign md_ready  = rst && !w_md_full;
  assign acc_ready = rst && !w_acc_full;

  // A handshake with rd==0 still completes, but nothing is queued.
  assign w_md_push  = md_valid && md_ready;
  assign w_md_enq   = w_md_push && (md_rd != '0);
  assign w_acc_push = acc_valid && acc_ready;
  assign w_acc_enq  = w_acc_push && (acc_rd != '0);

  wb_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_md_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_md_enq),
    .i_din   ({md_rd, md_data}),
    .i_pop   (w_md_pop),
    .o_dout  (w_md_dout),
    .o_full  (w_md_full),
    .o_empty (w_md_empty),
    .o_count (w_md_count)
  );

  wb_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_acc_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_acc_enq),
    .i_din   ({acc_rd, acc_data}),
    .i_pop   (w_acc_pop),
    .o_dout  (w_acc_dout),
    .o_full  (w_acc_full),
    .o_empty (w_acc_empty),
    .o_count (w_acc_count)
  );

  assign w_pipe_req = pipe_valid && (pipe_rd != '0) && !r_stall_req;

  always_comb begin
    w_grant = SRC_NONE;
    if (w_pipe_req)                     w_grant = SRC_PIPE;
    else if (!w_md_empty && !w_acc_empty) w_grant = r_rr_ptr;
    else if (!w_md_empty)               w_grant = SRC_MD;
    else if (!w_acc_empty)              w_grant = SRC_ACC;
  end

  assign w_md_pop  = (w_grant == SRC_MD);
  assign w_acc_pop = (w_grant == SRC_ACC);

  // Counters track how long a queued head has been passed over.
  always_comb begin
    w_md_starve_next  = r_md_starve;
    w_acc_starve_next = r_acc_starve;
    if (w_md_empty || w_md_pop)        w_md_starve_next = '0;
    else if (r_md_starve < STARVE_LIM) w_md_starve_next = r_md_starve + SCNT_W'(1);
    if (w_acc_empty || w_acc_pop)       w_acc_starve_next = '0;
    else if (r_acc_starve < STARVE_LIM) w_acc_starve_next = r_acc_starve + SCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr     <= SRC_MD;
      r_md_starve  <= '0;
      r_acc_starve <= '0;
      r_stall_req  <= 1'b0;
    end else begin
      if (w_grant == SRC_MD)       r_rr_ptr <= SRC_ACC;
      else if (w_grant == SRC_ACC) r_rr_ptr <= SRC_MD;
      r_md_starve  <= w_md_starve_next;
      r_acc_starve <= w_acc_starve_next;
      r_stall_req  <= (r_md_starve == STARVE_LIM) || (r_acc_starve == STARVE_LIM);
    end
  end

  // Address and data hold their last value when nothing is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      case (w_grant)
        SRC_PIPE: begin
          r_wb_en   <= 1'b1;
          r_wb_rd   <= pipe_rd;
          r_wb_data <= pipe_data;
        end
        SRC_MD: begin
          r_wb_en   <= 1'b1;
          r_wb_rd   <= w_md_dout[ENT_W-1 -: ADDR_W];
          r_wb_data <= w_md_dout[DATA_W-1:0];
        end
        SRC_ACC: begin
          r_wb_en   <= 1'b1;
          r_wb_rd   <= w_acc_dout[ENT_W-1 -: ADDR_W];
          r_wb_data <= w_acc_dout[DATA_W-1:0];
        end
        default: r_wb_en <= 1'b0;
      endcase
    end
  end

  assign stall_req = r_stall_req;
  assign wb_en     = r_wb_en;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign busy      = (w_md_count != '0) || (w_acc_count != '0) || r_wb_en;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      assert (!(pipe_valid && (pipe_rd != '0) && r_stall_req))
        else $error("wb_arbiter: pipeline write during stall_req dropped");
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: priority, round-robin, x0 filtering, starvation, reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, md_valid, acc_valid;
  logic [4:0]  pipe_rd, md_rd, acc_rd;
  logic [31:0] pipe_data, md_data, acc_data;
  logic        md_ready, acc_ready, stall_req, wb_en, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_pass  = 0;
  int n_total = 0;
  int n_wait;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_rd      (md_rd),
    .md_data    (md_data),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_rd     (acc_rd),
    .acc_data   (acc_data),
    .stall_req  (stall_req),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    $display("check %-18s got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    pipe_valid = 0; pipe_rd = '0; pipe_data = '0;
    md_valid = 0;   md_rd = '0;   md_data = '0;
    acc_valid = 0;  acc_rd = '0;  acc_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_md_ready", 32'(md_ready), 32'd0);
    chk("rst_acc_ready", 32'(acc_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("md_ready_up", 32'(md_ready), 32'd1);
    chk("acc_ready_up", 32'(acc_ready), 32'd1);

    // 1: single pipeline write, one-cycle latency
    pipe_valid = 1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    tick();
    pipe_valid = 0;
    chk("t1_wb_en", 32'(wb_en), 32'd1);
    chk("t1_wb_rd", 32'(wb_rd), 32'd5);
    chk("t1_wb_data", wb_data, 32'hDEADBEEF);
    tick();
    chk("t1_idle_en", 32'(wb_en), 32'd0);
    chk("t1_hold_rd", 32'(wb_rd), 32'd5);

    // 2: simultaneous side pushes, MD first after reset
    md_valid = 1;  md_rd = 5'd3;  md_data = 32'h11;
    acc_valid = 1; acc_rd = 5'd4; acc_data = 32'h22;
    tick();
    md_valid = 0; acc_valid = 0;
    chk("t2_push_en", 32'(wb_en), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    tick();
    chk("t2_first_rd", 32'(wb_rd), 32'd3);
    chk("t2_first_data", wb_data, 32'h11);
    tick();
    chk("t2_second_en", 32'(wb_en), 32'd1);
    chk("t2_second_rd", 32'(wb_rd), 32'd4);
    chk("t2_second_data", wb_data, 32'h22);
    tick();
    chk("t2_idle_en", 32'(wb_en), 32'd0);
    chk("t2_busy_low", 32'(busy), 32'd0);

    // 3: pipeline hogs the port until starvation stalls it
    pipe_valid = 1; pipe_rd = 5'd10; pipe_data = 32'hA0;
    md_valid = 1;   md_rd = 5'd7;    md_data = 32'h70;
    tick();
    chk("t3_pipe_rd", 32'(wb_rd), 32'd10);
    chk("t3_ready_1", 32'(md_ready), 32'd1);
    md_data = 32'h71;
    tick();
    md_valid = 0;
    chk("t3_ready_full", 32'(md_ready), 32'd0);
    n_wait = 0;
    while (!stall_req && n_wait < 20) begin
      tick();
      n_wait++;
    end
    pipe_valid = 0;
    chk("t3_stall_cycles", 32'(n_wait), 32'd8);
    chk("t3_last_pipe", 32'(wb_rd), 32'd10);
    tick();
    chk("t3_md0_en", 32'(wb_en), 32'd1);
    chk("t3_md0_rd", 32'(wb_rd), 32'd7);
    chk("t3_md0_data", wb_data, 32'h70);
    chk("t3_stall_hold", 32'(stall_req), 32'd1);
    tick();
    chk("t3_md1_data", wb_data, 32'h71);
    chk("t3_stall_clr", 32'(stall_req), 32'd0);
    tick();
    chk("t3_busy_low", 32'(busy), 32'd0);

    // 4: pipe write to x0 yields the slot to the accelerator
    acc_valid = 1; acc_rd = 5'd9; acc_data = 32'h99;
    tick();
    acc_valid = 0;
    pipe_valid = 1; pipe_rd = 5'd0; pipe_data = 32'h5;
    chk("t4_push_en", 32'(wb_en), 32'd0);
    tick();
    pipe_valid = 0;
    chk("t4_acc_en", 32'(wb_en), 32'd1);
    chk("t4_acc_rd", 32'(wb_rd), 32'd9);
    chk("t4_acc_data", wb_data, 32'h99);
    tick();
    chk("t4_idle_en", 32'(wb_en), 32'd0);

    // 5: accelerator push to x0 is accepted and discarded
    acc_valid = 1; acc_rd = 5'd0; acc_data = 32'h55;
    chk("t5_ready", 32'(acc_ready), 32'd1);
    tick();
    acc_valid = 0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready_after", 32'(acc_ready), 32'd1);
    tick();
    chk("t5_wb_en", 32'(wb_en), 32'd0);

    // 6: asynchronous reset with queued MD entries and a write in flight
    pipe_valid = 1; pipe_rd = 5'd12; pipe_data = 32'hC;
    md_valid = 1;   md_rd = 5'd13;   md_data = 32'hD1;
    tick();
    md_data = 32'hD2;
    tick();
    md_valid = 0;
    chk("t6_pre_en", 32'(wb_en), 32'd1);
    chk("t6_pre_full", 32'(md_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_en", 32'(wb_en), 32'd0);
    chk("t6_md_ready", 32'(md_ready), 32'd0);
    chk("t6_acc_ready", 32'(acc_ready), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    pipe_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("t6_post_en", 32'(wb_en), 32'd0);
    chk("t6_post_busy", 32'(busy), 32'd0);
    tick();
    chk("t6_no_stale", 32'(wb_en), 32'd0);
    chk("t6_ready_back", 32'(md_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-stage arbiter sitting directly upstream of the general-purpose register file's single write port.
- Merges three result producers into one registered write (wb_en/wb_rd/wb_data):
  - single-cycle pipeline results (ALU/load)
  - the multi-cycle MUL/DIV unit
  - the encryption accelerator
- Buffers multi-cycle results in small FIFOs and round-robins them when the pipeline is not writing.
- Filters writes to x0, since the register file does not protect register 0.

Parameters:
- DATA_W, 32, result/register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, entries per side-source FIFO (power of 2, >=2)
- STARVE_MAX, 8, cycles a FIFO head may wait before stall_req asserts

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- pipe_valid  in  1  pipeline result valid this cycle (no back-pressure)
- pipe_rd  in  ADDR_W  pipeline destination register
- pipe_data  in  DATA_W  pipeline result
- md_valid  in  1  MUL/DIV result valid
- md_ready  out  1  MUL/DIV FIFO can accept
- md_rd  in  ADDR_W  MUL/DIV destination
- md_data  in  DATA_W  MUL/DIV result
- acc_valid  in  1  accelerator result valid
- acc_ready  out  1  accelerator FIFO can accept
- acc_rd  in  ADDR_W  accelerator destination
- acc_data  in  DATA_W  accelerator result
- stall_req  out  1  core must hold pipe_valid low next cycle
- wb_en  out  1  register-file write enable
- wb_rd  out  ADDR_W  register-file write address
- wb_data  out  DATA_W  register-file write data
- busy  out  1  any FIFO non-empty or wb_en high

Behaviour:

Reset:
- rst low asynchronously clears wb_en, wb_rd, wb_data, stall_req, both FIFOs (empty), both starvation counters and rr_ptr (=MD).
- md_ready and acc_ready are forced 0 while rst low.
- busy = 0 after reset.

Handshake:
- Side source push occurs on valid && ready at the rising edge.
- ready = !full; it is derived from registered count only, with no combinational path from valid.
- Push with rd==0 completes the handshake but the entry is discarded (not enqueued).

Grant (one per cycle, evaluated combinationally, applied at the edge):
1. pipe_valid && pipe_rd!=0 && !stall_req -> grant PIPE.
2. Otherwise the non-empty FIFO(s): if both are non-empty, grant the one selected by rr_ptr; rr_ptr then toggles to the other.
3. If one is non-empty, grant it; rr_ptr points to the other.
4. pipe_valid with pipe_rd==0 is a no-op and frees the slot for a FIFO.

Output and latency:
- Outputs are registered: a granted write appears on wb_en/wb_rd/wb_data the next cycle.
- Latency is 1 cycle for pipe, and at least 2 cycles from push for side sources.
- With no grant, wb_en=0 and wb_rd/wb_data hold their last values.

FIFO boundaries:
- Pop and push in the same cycle is legal at any count except full, since ready is low when full.
- Count wraps never; overflow/underflow are assertion failures.
- Read/write pointers wrap modulo FIFO_DEPTH.

Starvation:
- Per-FIFO counter increments each cycle the FIFO is non-empty and not granted; it clears on grant or when empty; it saturates at STARVE_MAX.
- stall_req is registered; it is 1 in the cycle after either counter reaches STARVE_MAX, and clears in the cycle after both counters drop below it.
- While stall_req=1, pipe is excluded from grant.
- pipe_valid=1 with pipe_rd!=0 while stall_req=1 is a protocol violation: the result is dropped and an assertion fires.

Ordering:
- Per-source FIFO order is preserved.
- There is no ordering guarantee between sources; the hazard unit ensures no two outstanding producers target the same rd.

Reset mid-operation:
- FIFO contents and any in-flight wb_en are lost; wb_en drops immediately (asynchronously).

Decomposition:
- Package wb_pkg holds:
  - DATA_W/ADDR_W defaults
  - src_e enum {SRC_NONE, SRC_PIPE, SRC_MD, SRC_ACC}
  - the wb_entry struct {rd, data}
- Sub-module wb_fifo holds: parameterised depth, push/pop, full/empty/count, async active-low reset. It is instantiated twice (MD, ACC).
- Grant logic, rr_ptr, starvation counters and the output register live in wb_arbiter.

Test Plan:
1. Reset, then pipe_valid=1, rd=5, data=0xDEADBEEF for one cycle -> next cycle wb_en=1, wb_rd=5, wb_data=0xDEADBEEF; md_ready=acc_ready=1.
2. md push (rd=3, 0x11) and acc push (rd=4, 0x22) in the same cycle, pipe idle -> wb writes x3 then x4 on consecutive cycles (rr_ptr=MD after reset); busy drops after.
3. Pipe writes every cycle while md pushes rd=7 -> md_ready falls after 2 pushes; stall_req=1 after 8 waiting cycles; next cycle pipe is held and x7 is written.
4. pipe rd=0 data=0x5 concurrent with non-empty acc (rd=9) -> x0 is never written; x9 is written the next cycle.
5. acc push rd=0 -> acc_ready handshake completes, FIFO count unchanged, wb_en stays 0.
6. Two md entries queued, rst pulled low mid-cycle -> wb_en drops immediately, md/acc_ready=0; after release FIFOs are empty and no stale write is issued.
